// File: rtl/bcd_display_scan.sv
// Purpose: time-multiplexed 7-segment scanner for DIGITS BCD digits with leading-zero blanking.
// Latency: load->seg 2 cycles; idx/shadow->seg/an 1 cycle (registered outputs).
// Backpressure: none; en=0 freezes the scan and darkens the display.
module bcd_display_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shadow;

    logic                slot_end;
    logic                frame_wrap;
    logic [3:0]          cur_dig;
    logic [DIGITS-1:0]   zero_from;
    logic                all_zero;
    logic                blank_cur;
    logic [DIGITS-1:0]   an_nxt;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign slot_end   = en && (presc == PMAX);
    assign frame_wrap = slot_end && (idx == IMAX);

    always_comb begin
        cur_dig = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_dig = shadow[4*k +: 4];
            end
        end
    end

    // zero_from[k]: digit k and every digit above it are zero (codes 10..15 count as nonzero).
    always_comb begin
        all_zero  = 1'b1;
        zero_from = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero     = all_zero && (shadow[4*k +: 4] == 4'd0);
            zero_from[k] = all_zero;
        end
    end

    assign blank_cur = blank_lz && (idx != '0) && zero_from[idx];

    always_comb begin
        an_nxt      = '0;
        an_nxt[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            shadow     <= '0;
            seg        <= '0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                shadow <= bcd_in;
            end
            if (en) begin
                presc <= slot_end ? '0 : presc + 1'b1;
                if (slot_end) begin
                    idx <= (idx == IMAX) ? '0 : idx + 1'b1;
                end
            end
            frame_done <= frame_wrap;
            // Outputs come from the pre-edge shadow, so a load on an advance edge shows next cycle.
            if (en && !blank_cur) begin
                seg <= dec7(cur_dig);
                an  <= an_nxt;
            end else begin
                seg <= '0;
                an  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with DIGITS=4, DIV=4.
module tb_bcd_display_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    bcd_display_scan #(.DIGITS(4), .DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, load a value with the scan stopped, then enable: tick k afterwards shows slot (k/4)%4.
    task automatic start_scan(input logic [15:0] val, input logic blz);
        rst = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        rst = 1'b0; load = 1'b1; bcd_in = val;
        tick();
        load = 1'b0; blank_lz = blz; en = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        rst = 1'b1; en = 1'b1; load = 1'b0; bcd_in = 16'h0; blank_lz = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if (seg !== 7'h00) $display("FAIL reset_seg got %h want 00", seg); else pass_cnt++;
        chk_cnt++;
        if (an !== 4'b0000) $display("FAIL reset_an got %b want 0000", an); else pass_cnt++;
        chk_cnt++;
        if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done); else pass_cnt++;
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            ea = 4'b0001 << (k / 4);
            chk_cnt++;
            if (an !== ea || seg !== 7'h3F)
                $display("FAIL reset_scan k=%0d an=%b seg=%h want an=%b seg=3f", k, an, seg, ea);
            else pass_cnt++;
        end
    endtask

    task automatic test_digits();
        logic [6:0] es [4];
        logic [3:0] ea;
        int fd_cnt, fd_first, fd_second;
        es = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        fd_cnt = 0; fd_first = -1; fd_second = -1;
        start_scan(16'h1234, 1'b0);
        for (int k = 0; k < 32; k++) begin
            tick();
            ea = 4'b0001 << ((k / 4) % 4);
            chk_cnt++;
            if (an !== ea || seg !== es[(k / 4) % 4])
                $display("FAIL digits k=%0d an=%b seg=%h want an=%b seg=%h", k, an, seg, ea, es[(k / 4) % 4]);
            else pass_cnt++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = k; else fd_second = k;
            end
        end
        chk_cnt++;
        if (fd_cnt !== 2) $display("FAIL frame_count got %0d want 2", fd_cnt); else pass_cnt++;
        chk_cnt++;
        if (fd_second - fd_first !== 16)
            $display("FAIL frame_period got %0d want 16", fd_second - fd_first);
        else pass_cnt++;
    endtask

    task automatic test_blank();
        logic [15:0] vals [3];
        logic [6:0]  es   [3][4];
        logic [3:0]  ea   [3][4];
        vals = '{16'h0070, 16'h0000, 16'h1004};
        es = '{'{7'h3F, 7'h07, 7'h00, 7'h00},
               '{7'h3F, 7'h00, 7'h00, 7'h00},
               '{7'h66, 7'h3F, 7'h3F, 7'h06}};
        ea = '{'{4'b0001, 4'b0010, 4'b0000, 4'b0000},
               '{4'b0001, 4'b0000, 4'b0000, 4'b0000},
               '{4'b0001, 4'b0010, 4'b0100, 4'b1000}};
        for (int v = 0; v < 3; v++) begin
            start_scan(vals[v], 1'b1);
            for (int k = 0; k < 16; k++) begin
                tick();
                chk_cnt++;
                if (an !== ea[v][k / 4] || seg !== es[v][k / 4])
                    $display("FAIL blank val=%h k=%0d an=%b seg=%h want an=%b seg=%h",
                             vals[v], k, an, seg, ea[v][k / 4], es[v][k / 4]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_error_code();
        logic [15:0] vals [3];
        logic        blz  [3];
        logic [6:0]  es   [3][4];
        logic [3:0]  ea   [3][4];
        vals = '{16'h00A5, 16'h00A5, 16'hA000};
        blz  = '{1'b0, 1'b1, 1'b1};
        es = '{'{7'h6D, 7'h40, 7'h3F, 7'h3F},
               '{7'h6D, 7'h40, 7'h00, 7'h00},
               '{7'h3F, 7'h3F, 7'h3F, 7'h40}};
        ea = '{'{4'b0001, 4'b0010, 4'b0100, 4'b1000},
               '{4'b0001, 4'b0010, 4'b0000, 4'b0000},
               '{4'b0001, 4'b0010, 4'b0100, 4'b1000}};
        for (int v = 0; v < 3; v++) begin
            start_scan(vals[v], blz[v]);
            for (int k = 0; k < 16; k++) begin
                tick();
                chk_cnt++;
                if (an !== ea[v][k / 4] || seg !== es[v][k / 4])
                    $display("FAIL errcode val=%h blz=%b k=%0d an=%b seg=%h want an=%b seg=%h",
                             vals[v], blz[v], k, an, seg, ea[v][k / 4], es[v][k / 4]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_pause();
        logic [6:0] es [4];
        logic [3:0] ea;
        es = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        start_scan(16'h1234, 1'b0);
        for (int k = 0; k < 18; k++) begin
            if (k == 6) begin
                en = 1'b0;
                for (int p = 0; p < 10; p++) begin
                    tick();
                    chk_cnt++;
                    if (an !== 4'b0000 || seg !== 7'h00 || frame_done !== 1'b0)
                        $display("FAIL pause p=%0d an=%b seg=%h fd=%b want 0/0/0", p, an, seg, frame_done);
                    else pass_cnt++;
                end
                en = 1'b1;
            end
            tick();
            ea = 4'b0001 << ((k / 4) % 4);
            chk_cnt++;
            if (an !== ea || seg !== es[(k / 4) % 4])
                $display("FAIL resume k=%0d an=%b seg=%h want an=%b seg=%h", k, an, seg, ea, es[(k / 4) % 4]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        start_scan(16'h1234, 1'b0);
        tick(); tick(); tick();
        load = 1'b1; bcd_in = 16'h5678;
        tick();
        load = 1'b0;
        chk_cnt++;
        if (an !== 4'b0001 || seg !== 7'h66)
            $display("FAIL load_at_advance an=%b seg=%h want an=0001 seg=66", an, seg);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_cnt++;
            if (an !== 4'b0010 || seg !== 7'h07)
                $display("FAIL load_new k=%0d an=%b seg=%h want an=0010 seg=07", k, an, seg);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_load();
        logic [3:0] ea;
        start_scan(16'h1234, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1; load = 1'b1; bcd_in = 16'h9999;
        tick();
        chk_cnt++;
        if (an !== 4'b0000 || seg !== 7'h00 || frame_done !== 1'b0)
            $display("FAIL rst_load an=%b seg=%h fd=%b want 0/0/0", an, seg, frame_done);
        else pass_cnt++;
        rst = 1'b0; load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ea = 4'b0001 << (k / 4);
            chk_cnt++;
            if (an !== ea || seg !== 7'h3F)
                $display("FAIL rst_restart k=%0d an=%b seg=%h want an=%b seg=3f", k, an, seg, ea);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = 16'h0; blank_lz = 1'b0;
        test_reset();
        test_digits();
        test_blank();
        test_error_code();
        test_pause();
        test_back_to_back();
        test_reset_load();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
